multicaster: RTL and testbench

MULTICASTER -- requirements
Module: multicaster

---
 rtl/multicaster.sv | 198 +++++++++++++++++++
 tb/tb_multicaster.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicaster.sv
// Per-column multicaster: forwards BUS beats tagged with this column's id to the PE
// through a 2-entry FIFO and returns the PE result. Optional stall counter: MCAST_STALL_CNT_EN.
module multicaster #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_COL    = 4,
    localparam int IW        = (NUM_COL > 1) ? $clog2(NUM_COL) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    caster_en,
    input  logic [IW-1:0]           id,
    input  logic [7:0]              kernel_size,
    input  logic                    b_valid,
    output logic                    b_ready,
    input  logic [IW-1:0]           b_tag,
    input  logic [DATA_WIDTH-1:0]   ifmap_b2m,
    input  logic [DATA_WIDTH-1:0]   fltr_b2m,
    input  logic [2*DATA_WIDTH-1:0] psum_b2m,
    output logic                    pe_en,
    input  logic                    pe_ready,
    output logic [DATA_WIDTH-1:0]   ifmap_m2p,
    output logic [DATA_WIDTH-1:0]   fltr_m2p,
    output logic [2*DATA_WIDTH-1:0] psum_m2p,
    input  logic                    pe_valid,
    input  logic [2*DATA_WIDTH-1:0] psum_p2m,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [2*DATA_WIDTH-1:0] psum_m2b,
    output logic [7:0]              ksize_q
`ifdef MCAST_STALL_CNT_EN
    ,
    output logic [15:0]             stall_cnt
`endif
);

    localparam int EW = 4 * DATA_WIDTH;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never depends on ready. b_valid/b_ready, pe_en/pe_ready, m_valid/m_ready.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        WAIT   = 2'd2,
        RETURN = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [7:0]              ksize_d;
    logic [7:0]              acc_cnt_q, acc_cnt_d;
    logic [7:0]              dlv_cnt_q, dlv_cnt_d;
    logic [EW-1:0]           mem_q [2];
    logic [EW-1:0]           mem_d [2];
    logic                    rd_ptr_q, rd_ptr_d;
    logic                    wr_ptr_q, wr_ptr_d;
    logic [1:0]              cnt_q, cnt_d;
    logic [2*DATA_WIDTH-1:0] psum_m2b_q, psum_m2b_d;

    logic [7:0] k_eff;
    logic       tag_hit;
    logic       push;
    logic       pop;

    assign k_eff   = (ksize_q == 8'd0) ? 8'd1 : ksize_q;
    assign tag_hit = (b_tag == id);

    always_comb begin
        b_ready = 1'b0;
        if (state_q != IDLE) begin
            if (!tag_hit) begin
                b_ready = 1'b1;
            end else if (state_q == STREAM && caster_en &&
                         cnt_q < 2'd2 && acc_cnt_q < k_eff) begin
                b_ready = 1'b1;
            end
        end
    end

    assign push     = b_valid && b_ready && tag_hit;
    assign pe_en    = (state_q == STREAM) && (cnt_q != 2'd0);
    assign pop      = pe_en && pe_ready;
    assign m_valid  = (state_q == RETURN);
    assign psum_m2b = psum_m2b_q;

    assign {ifmap_m2p, fltr_m2p, psum_m2p} = mem_q[rd_ptr_q];

    always_comb begin
        state_d    = state_q;
        ksize_d    = ksize_q;
        acc_cnt_d  = acc_cnt_q;
        dlv_cnt_d  = dlv_cnt_q;
        mem_d      = mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        cnt_d      = cnt_q;
        psum_m2b_d = psum_m2b_q;

        // Push is only possible below full and pop only above empty, so a
        // simultaneous push/pop never wraps the count.
        if (push) begin
            mem_d[wr_ptr_q] = {ifmap_b2m, fltr_b2m, psum_b2m};
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};

        if (!caster_en) begin
            state_d   = IDLE;
            acc_cnt_d = 8'd0;
            dlv_cnt_d = 8'd0;
            rd_ptr_d  = 1'b0;
            wr_ptr_d  = 1'b0;
            cnt_d     = 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d   = STREAM;
                    ksize_d   = kernel_size;
                    acc_cnt_d = 8'd0;
                    dlv_cnt_d = 8'd0;
                end
                STREAM: begin
                    acc_cnt_d = acc_cnt_q + {7'd0, push};
                    dlv_cnt_d = dlv_cnt_q + {7'd0, pop};
                    if (pop && ({1'b0, dlv_cnt_q} + 9'd1 == {1'b0, k_eff})) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (pe_valid) begin
                        psum_m2b_d = psum_p2m;
                        state_d    = RETURN;
                    end
                end
                RETURN: begin
                    if (m_ready) begin
                        state_d   = STREAM;
                        ksize_d   = kernel_size;
                        acc_cnt_d = 8'd0;
                        dlv_cnt_d = 8'd0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ksize_q    <= 8'd0;
            acc_cnt_q  <= 8'd0;
            dlv_cnt_q  <= 8'd0;
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            cnt_q      <= 2'd0;
            psum_m2b_q <= '0;
        end else begin
            state_q    <= state_d;
            ksize_q    <= ksize_d;
            acc_cnt_q  <= acc_cnt_d;
            dlv_cnt_q  <= dlv_cnt_d;
            mem_q[0]   <= mem_d[0];
            mem_q[1]   <= mem_d[1];
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
            psum_m2b_q <= psum_m2b_d;
        end
    end

`ifdef MCAST_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q == IDLE) begin
            stall_cnt_d = 16'd0;
        end else if (pe_en && !pe_ready && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_multicaster.sv
// Self-checking bench for multicaster: beat scoreboard on the PE side plus
// directed checks of the result return, drop, stall, abort and reset behaviour.
module tb_multicaster;

    localparam int DW = 16;
    localparam int NC = 4;
    localparam int IW = 2;
    localparam int EW = 4 * DW;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_RETURN = 2'd3;

    logic            clk;
    logic            rst_n;
    logic            caster_en;
    logic [IW-1:0]   id;
    logic [7:0]      kernel_size;
    logic            b_valid;
    logic            b_ready;
    logic [IW-1:0]   b_tag;
    logic [DW-1:0]   ifmap_b2m, fltr_b2m;
    logic [2*DW-1:0] psum_b2m;
    logic            pe_en;
    logic            pe_ready;
    logic [DW-1:0]   ifmap_m2p, fltr_m2p;
    logic [2*DW-1:0] psum_m2p;
    logic            pe_valid;
    logic [2*DW-1:0] psum_p2m;
    logic            m_valid;
    logic            m_ready;
    logic [2*DW-1:0] psum_m2b;
    logic [7:0]      ksize_q;
`ifdef MCAST_STALL_CNT_EN
    logic [15:0]     stall_cnt;
`endif

    multicaster #(.DATA_WIDTH(DW), .NUM_COL(NC)) dut (
        .clk(clk), .rst_n(rst_n), .caster_en(caster_en), .id(id),
        .kernel_size(kernel_size), .b_valid(b_valid), .b_ready(b_ready),
        .b_tag(b_tag), .ifmap_b2m(ifmap_b2m), .fltr_b2m(fltr_b2m),
        .psum_b2m(psum_b2m), .pe_en(pe_en), .pe_ready(pe_ready),
        .ifmap_m2p(ifmap_m2p), .fltr_m2p(fltr_m2p), .psum_m2p(psum_m2p),
        .pe_valid(pe_valid), .psum_p2m(psum_p2m), .m_valid(m_valid),
        .m_ready(m_ready), .psum_m2b(psum_m2b), .ksize_q(ksize_q)
`ifdef MCAST_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_pops  = 0;
    bit          mon_on  = 0;
    logic [EW-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // PE-side monitor: every pop must match the oldest accepted matching beat.
    always @(negedge clk) begin
        #2;
        if (mon_on && rst_n && pe_en && pe_ready) begin
            n_pops++;
            if (exp_q.size() == 0) begin
                check_eq("pe_en_with_nothing_sent", {63'd0, pe_en}, 64'd0);
            end else begin
                check_eq("pe_data", {ifmap_m2p, fltr_m2p, psum_m2p}, exp_q.pop_front());
            end
        end
    end

    // driver: called at a negedge, returns at a negedge
    task automatic send_beat(input logic [IW-1:0] tag, input logic [DW-1:0] ifm,
                             input logic [DW-1:0] flt, input logic [2*DW-1:0] ps,
                             input int budget, output bit ok);
        ok        = 1'b0;
        b_valid   = 1'b1;
        b_tag     = tag;
        ifmap_b2m = ifm;
        fltr_b2m  = flt;
        psum_b2m  = ps;
        for (int i = 0; i < budget; i++) begin
            #1;
            if (b_ready) begin
                ok = 1'b1;
                if (tag == id) exp_q.push_back({ifm, flt, ps});
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        b_valid = 1'b0;
    endtask

    task automatic wait_state(input logic [1:0] st, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (logic'(dut.state_q == st)) break;
            @(negedge clk);
        end
        check_eq(tag, dut.state_q, st);
    endtask

    task automatic finish_result(input logic [2*DW-1:0] val, input logic [7:0] next_k);
        wait_state(S_WAIT, 20, "reach_wait");
        kernel_size = next_k;
        pe_valid    = 1'b1;
        psum_p2m    = val;
        @(negedge clk);
        pe_valid = 1'b0;
        check_eq("ret_m_valid", m_valid, 1'b1);
        check_eq("ret_psum", psum_m2b, val);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        check_eq("ret_to_stream", dut.state_q, S_STREAM);
        check_eq("ksize_relatch", ksize_q, next_k);
        check_eq("sb_drained", exp_q.size(), 0);
    endtask

    bit              ok;
    int              p0;
    int              n_hit;
    logic [DW-1:0]   d_if [5];
    logic [DW-1:0]   d_fl [5];
    logic [2*DW-1:0] d_ps [5];
    logic [1:0]      tags [7];
`ifdef MCAST_STALL_CNT_EN
    logic [15:0]     s0;
`endif

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; caster_en = 1'b0; id = 2'd2; kernel_size = 8'd0;
        b_valid = 1'b0; b_tag = '0; ifmap_b2m = '0; fltr_b2m = '0; psum_b2m = '0;
        pe_ready = 1'b0; pe_valid = 1'b0; psum_p2m = '0; m_ready = 1'b0;
        repeat (3) @(negedge clk);

        // reset state
        check_eq("rst_state", dut.state_q, S_IDLE);
        check_eq("rst_b_ready", b_ready, 1'b0);
        check_eq("rst_pe_en", pe_en, 1'b0);
        check_eq("rst_m_valid", m_valid, 1'b0);
        check_eq("rst_psum_m2b", psum_m2b, 0);
        check_eq("rst_ksize", ksize_q, 0);
        check_eq("rst_m2p", {ifmap_m2p, fltr_m2p, psum_m2p}, 0);
        rst_n  = 1'b1;
        mon_on = 1'b1;
        @(negedge clk);
        check_eq("idle_hold", dut.state_q, S_IDLE);

        // K=3 in-order forwarding; pe_valid outside WAIT ignored
        kernel_size = 8'd3; caster_en = 1'b1; pe_ready = 1'b1;
        @(negedge clk);
        check_eq("enter_stream", dut.state_q, S_STREAM);
        check_eq("ksize_latch", ksize_q, 8'd3);
        kernel_size = 8'd9;
        pe_valid = 1'b1; psum_p2m = 32'd99;
        @(negedge clk);
        pe_valid = 1'b0;
        check_eq("pe_valid_ignored_state", dut.state_q, S_STREAM);
        check_eq("pe_valid_ignored_psum", psum_m2b, 0);
        check_eq("ksize_stable", ksize_q, 8'd3);
        p0 = n_pops;
        for (int i = 0; i < 3; i++) begin
            send_beat(2'd2, 16'(i + 1), 16'(i + 4), 32'($urandom_range(0, 1000)), 10, ok);
            check_eq("k3_accept", ok, 1'b1);
        end
        wait_state(S_WAIT, 10, "k3_wait");
        check_eq("k3_pops", n_pops - p0, 3);

        // WAIT -> RETURN, hold across m_ready=0, second pe_valid ignored
        kernel_size = 8'd4;
        pe_valid = 1'b1; psum_p2m = 32'd32;
        @(negedge clk);
        psum_p2m = 32'd77;
        for (int i = 0; i < 3; i++) begin
            check_eq("hold_m_valid", m_valid, 1'b1);
            check_eq("hold_psum", psum_m2b, 32'd32);
            @(negedge clk);
        end
        pe_valid = 1'b0;
        check_eq("hold_psum_after", psum_m2b, 32'd32);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        check_eq("return_stream", dut.state_q, S_STREAM);
        check_eq("return_m_valid", m_valid, 1'b0);
        check_eq("return_ksize", ksize_q, 8'd4);
        check_eq("return_acc_clr", dut.acc_cnt_q, 0);

        // foreign-tag beats interleaved: consumed, never forwarded
        tags = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd1, 2'd2};
        n_hit = 0;
        for (int i = 0; i < 7; i++) begin
            send_beat(tags[i], (tags[i] == 2'd1) ? 16'hDEAD : 16'($urandom_range(0, 255)),
                      16'($urandom_range(0, 255)), 32'($urandom_range(0, 65535)), 10, ok);
            check_eq("mix_accept", ok, 1'b1);
            if (tags[i] == 2'd2) n_hit++;
            if (n_hit < 4) check_eq("mix_acc_cnt", dut.acc_cnt_q, n_hit);
        end
        finish_result(32'($urandom_range(1, 60000)), 8'd5);

        // back-pressure: FIFO fills at 2, third matching beat stalls
        pe_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            d_if[i] = 16'($urandom_range(0, 65535));
            d_fl[i] = 16'($urandom_range(0, 65535));
            d_ps[i] = 32'($urandom_range(0, 65535));
        end
        send_beat(2'd2, d_if[0], d_fl[0], d_ps[0], 10, ok);
        check_eq("bp_first", ok, 1'b1);
        send_beat(2'd2, d_if[1], d_fl[1], d_ps[1], 10, ok);
        check_eq("bp_second", ok, 1'b1);
`ifdef MCAST_STALL_CNT_EN
        s0 = stall_cnt;
`endif
        send_beat(2'd2, d_if[2], d_fl[2], d_ps[2], 4, ok);
        check_eq("bp_third_stalls", ok, 1'b0);
        check_eq("bp_fifo_full", dut.cnt_q, 2);
`ifdef MCAST_STALL_CNT_EN
        check_eq("stall_cnt_incr", stall_cnt, s0 + 16'd4);
`endif
        pe_ready = 1'b1;
        for (int i = 2; i < 5; i++) begin
            send_beat(2'd2, d_if[i], d_fl[i], d_ps[i], 10, ok);
            check_eq("bp_resume", ok, 1'b1);
        end
        finish_result(32'($urandom_range(1, 60000)), 8'd0);

        // kernel_size 0 acts as 1
        p0 = n_pops;
        send_beat(2'd2, 16'h0011, 16'h0022, 32'h33, 10, ok);
        check_eq("k0_first", ok, 1'b1);
        send_beat(2'd2, 16'h0044, 16'h0055, 32'h66, 4, ok);
        check_eq("k0_second_refused", ok, 1'b0);
        check_eq("k0_pops", n_pops - p0, 1);
        finish_result(32'h1234, 8'd3);

        // abort with one entry buffered
        pe_ready = 1'b0;
        send_beat(2'd2, 16'h0101, 16'h0202, 32'h0303, 10, ok);
        check_eq("abort_accept", ok, 1'b1);
        caster_en = 1'b0;
        @(negedge clk);
        check_eq("abort_idle", dut.state_q, S_IDLE);
        check_eq("abort_pe_en", pe_en, 1'b0);
        check_eq("abort_fifo_empty", dut.cnt_q, 0);
        exp_q.delete();

        // reset in the middle of RETURN
        caster_en = 1'b1; pe_ready = 1'b1;
        @(negedge clk);
        check_eq("reenter_ksize", ksize_q, 8'd3);
        for (int i = 0; i < 3; i++) begin
            send_beat(2'd2, 16'(i + 10), 16'(i + 20), 32'(i + 30), 10, ok);
            check_eq("pre_rst_accept", ok, 1'b1);
        end
        wait_state(S_WAIT, 10, "pre_rst_wait");
        pe_valid = 1'b1; psum_p2m = 32'd55;
        @(negedge clk);
        pe_valid = 1'b0;
        check_eq("pre_rst_m_valid", m_valid, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_m_valid", m_valid, 1'b0);
        check_eq("rst_mid_psum", psum_m2b, 0);
        check_eq("rst_mid_state", dut.state_q, S_IDLE);
        check_eq("rst_mid_ksize", ksize_q, 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
